// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the fetch stage
// and the memory controller; single outstanding miss, registered outputs only.
module icache_direct #(
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jp_wrong,
    input  logic [31:0] pc_in,
    input  logic        is_stall_IC,
    output logic        ins_flag,
    output logic [31:0] ins,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_ins
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state, state_n;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic                  flushed, flushed_n;
    logic                  ins_flag_n;
    logic                  mc_req_n;
    logic [31:0]           ins_n;
    logic [31:0]           mc_addr_n;
    logic                  fill;

    logic [INDEX_BITS-1:0] idx;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  hit;
    logic                  unused_bits;

    assign idx         = pc_in[INDEX_BITS+1:2];
    assign pc_tag      = pc_in[31:INDEX_BITS+2];
    // mc_addr doubles as the latched miss address for the refill
    assign fill_idx    = mc_addr[INDEX_BITS+1:2];
    assign hit         = valid[idx] && (tag_mem[idx] == pc_tag);
    assign unused_bits = ^{pc_in[1:0], mc_addr[1:0]};

    always_comb begin
        state_n    = state;
        flushed_n  = flushed;
        ins_flag_n = 1'b0;
        ins_n      = ins;
        mc_req_n   = mc_req;
        mc_addr_n  = mc_addr;
        fill       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!jp_wrong && !is_stall_IC) begin
                    if (hit) begin
                        ins_flag_n = 1'b1;
                        ins_n      = data_mem[idx];
                    end else begin
                        mc_addr_n = {pc_in[31:2], 2'b00};
                        mc_req_n  = 1'b1;
                        flushed_n = 1'b0;
                        state_n   = FETCH;
                    end
                end
            end
            FETCH: begin
                if (jp_wrong) flushed_n = 1'b1;
                // Always refill on completion; only delivery is suppressed after a flush
                if (mc_done) begin
                    fill       = 1'b1;
                    mc_req_n   = 1'b0;
                    ins_n      = mc_ins;
                    ins_flag_n = !(flushed || jp_wrong);
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            flushed  <= 1'b0;
            ins_flag <= 1'b0;
            ins      <= '0;
            mc_req   <= 1'b0;
            mc_addr  <= '0;
            valid    <= '0;
        end else if (rdy) begin
            state    <= state_n;
            flushed  <= flushed_n;
            ins_flag <= ins_flag_n;
            ins      <= ins_n;
            mc_req   <= mc_req_n;
            mc_addr  <= mc_addr_n;
            if (fill) valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill) begin
            tag_mem[fill_idx]  <= mc_addr[31:INDEX_BITS+2];
            data_mem[fill_idx] <= mc_ins;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: the bench plays the memory controller and
// queues the expected registered outputs for every cycle it drives.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        jp_wrong = 1'b0;
    logic [31:0] pc_in = '0;
    logic        is_stall_IC = 1'b0;
    logic        ins_flag;
    logic [31:0] ins;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done = 1'b0;
    logic [31:0] mc_ins = '0;

    int total  = 0;
    int passed = 0;

    typedef struct {
        string       tag;
        logic        flag;
        logic [31:0] word;
        logic        chk_word;
        logic        req;
        logic [31:0] addr;
        logic        chk_addr;
    } exp_t;

    exp_t sb[$];

    icache_direct #(.INDEX_BITS(8)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .jp_wrong(jp_wrong),
        .pc_in(pc_in),
        .is_stall_IC(is_stall_IC),
        .ins_flag(ins_flag),
        .ins(ins),
        .mc_req(mc_req),
        .mc_addr(mc_addr),
        .mc_done(mc_done),
        .mc_ins(mc_ins)
    );

    always #5 clk = ~clk;

    // Backing-store contents the fake memory controller returns
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00100093;
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic exp_t mk(input string tag, input logic flag, input logic [31:0] word,
                                input logic chk_word, input logic req, input logic [31:0] addr,
                                input logic chk_addr);
        exp_t e;
        e.tag = tag; e.flag = flag; e.word = word; e.chk_word = chk_word;
        e.req = req; e.addr = addr; e.chk_addr = chk_addr;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, then compare the registered outputs it produced
    task automatic applyStimulus(input logic [31:0] pc, input logic stall, input logic jp,
                                 input logic done, input logic [31:0] word, input exp_t e);
        exp_t got;
        pc_in = pc; is_stall_IC = stall; jp_wrong = jp; mc_done = done; mc_ins = word;
        sb.push_back(e);
        @(posedge clk);
        #1;
        is_stall_IC = 1'b0; jp_wrong = 1'b0; mc_done = 1'b0;
        got = sb.pop_front();
        checkOutput({got.tag, ".flag"}, {31'b0, ins_flag}, {31'b0, got.flag});
        checkOutput({got.tag, ".req"}, {31'b0, mc_req}, {31'b0, got.req});
        if (got.chk_word) checkOutput({got.tag, ".ins"}, ins, got.word);
        if (got.chk_addr) checkOutput({got.tag, ".addr"}, mc_addr, got.addr);
    endtask

    task automatic fetchHit(input string tag, input logic [31:0] pc);
        applyStimulus(pc, 1'b0, 1'b0, 1'b0, '0, mk(tag, 1'b1, mem_word(pc), 1'b1, 1'b0, '0, 1'b0));
    endtask

    task automatic fetchMiss(input string tag, input logic [31:0] pc, input int latency,
                             input int flush_at);
        applyStimulus(pc, 1'b0, 1'b0, 1'b0, '0, mk({tag, "_req"}, 1'b0, '0, 1'b0, 1'b1, pc, 1'b1));
        for (int i = 0; i < latency; i++)
            applyStimulus(pc, 1'b0, (i == flush_at), 1'b0, '0,
                          mk({tag, "_wait"}, 1'b0, '0, 1'b0, 1'b1, pc, 1'b1));
        applyStimulus(pc, 1'b0, 1'b0, 1'b1, mem_word(pc),
                      mk({tag, "_done"}, (flush_at < 0), mem_word(pc), 1'b1, 1'b0, pc, 1'b1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.flag", {31'b0, ins_flag}, 32'h0);
        checkOutput("reset.ins", ins, 32'h0);
        checkOutput("reset.req", {31'b0, mc_req}, 32'h0);
        checkOutput("reset.addr", mc_addr, 32'h0);
        rst = 1'b0;

        fetchMiss("cold0", 32'h0, 2, -1);
        fetchHit("hit0", 32'h0);

        fetchMiss("load4", 32'h4, 1, -1);
        fetchMiss("load8", 32'h8, 1, -1);
        fetchHit("stream0", 32'h0);
        fetchHit("stream4", 32'h4);
        fetchHit("stream8", 32'h8);

        fetchMiss("conf400", 32'h400, 1, -1);
        fetchMiss("refetch0", 32'h0, 1, -1);

        fetchMiss("flush100", 32'h100, 3, 1);
        fetchHit("flushhit100", 32'h100);

        applyStimulus(32'h4, 1'b1, 1'b0, 1'b0, '0, mk("bubble", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0));
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, '0, mk("idleflush", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0));
        fetchHit("afterbubble", 32'h4);

        fetchHit("rdyhit0", 32'h0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(32'h4, 1'b0, 1'b0, 1'b0, '0,
                          mk("frozen", 1'b1, mem_word(32'h0), 1'b1, 1'b0, '0, 1'b0));
        rdy = 1'b1;
        fetchHit("rdyhit4", 32'h4);

        applyStimulus(32'h300, 1'b0, 1'b0, 1'b0, '0, mk("miss300_req", 1'b0, '0, 1'b0, 1'b1, 32'h300, 1'b1));
        rst = 1'b1;
        applyStimulus(32'h300, 1'b0, 1'b0, 1'b0, '0, mk("rstfetch", 1'b0, '0, 1'b1, 1'b0, '0, 1'b1));
        rst = 1'b0;
        fetchMiss("postrst0", 32'h0, 1, -1);
        fetchMiss("postrst8", 32'h8, 2, -1);
        fetchHit("postrsthit8", 32'h8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
